// File: rtl/fastica_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fastica_pkg
//  Description : Shared definitions for the FastICA covariance front end.
//                Holds the covariance sequencer state encoding and the
//                default sample-count width and divider latency.
//  Revision    : 1.0  initial release
// ============================================================================
package fastica_pkg;

    // Width of the sample count / sample address.
    localparam int N_W_DEFAULT     = 10;

    // Number of cycles the divide-by-N stage needs its enable held.
    localparam int DIV_LAT_DEFAULT = 4;

    // Covariance sequencer states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FETCH = 3'd2,
        MULT  = 3'd3,
        ACC   = 3'd4,
        DIV   = 3'd5,
        DONE  = 3'd6
    } cov_state_e;

    // One-hot strobe vector width driven by the sequencer
    // (SAMPLE_RD, ACC_CLR, EN_MULTI, EN_ACC, EN_DIV, COV_DONE).
    localparam int N_STROBES = 6;

endpackage : fastica_pkg
`default_nettype wire

// File: rtl/cov_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : cov_sequencer_if
//  Description : Control/strobe bundle between a requester and the covariance
//                sequencer.
//                  GO, N_SAMPLES          : start request and sample count
//                  ABORT                  : run abort (only with
//                                           COV_SEQ_ABORT_EN defined)
//                  SAMPLE_RD, SAMPLE_ADDR : centred-sample buffer read
//                  ACC_CLR                : accumulator clear
//                  EN_MULTI/EN_ACC/EN_DIV : datapath stage clock enables
//                  COV_BUSY, COV_DONE     : status
//                modport master : requester / datapath side
//                modport slave  : the sequencer itself
//  Revision    : 1.0  initial release
// ============================================================================
interface cov_sequencer_if #(
    parameter int N_W = fastica_pkg::N_W_DEFAULT
) ();
    import fastica_pkg::*;

    logic           GO;
    logic [N_W-1:0] N_SAMPLES;
`ifdef COV_SEQ_ABORT_EN
    logic           ABORT;
`endif
    logic           SAMPLE_RD;
    logic [N_W-1:0] SAMPLE_ADDR;
    logic           ACC_CLR;
    logic           EN_MULTI;
    logic           EN_ACC;
    logic           EN_DIV;
    logic           COV_BUSY;
    logic           COV_DONE;

    modport master (
`ifdef COV_SEQ_ABORT_EN
        output ABORT,
`endif
        output GO,
        output N_SAMPLES,
        input  SAMPLE_RD,
        input  SAMPLE_ADDR,
        input  ACC_CLR,
        input  EN_MULTI,
        input  EN_ACC,
        input  EN_DIV,
        input  COV_BUSY,
        input  COV_DONE
    );

    modport slave (
`ifdef COV_SEQ_ABORT_EN
        input  ABORT,
`endif
        input  GO,
        input  N_SAMPLES,
        output SAMPLE_RD,
        output SAMPLE_ADDR,
        output ACC_CLR,
        output EN_MULTI,
        output EN_ACC,
        output EN_DIV,
        output COV_BUSY,
        output COV_DONE
    );

endinterface : cov_sequencer_if
`default_nettype wire

// File: rtl/cov_lat_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : cov_lat_cnt
//  Description : Down-counter timing the divide phase of the covariance
//                sequencer. i_load presets DIV_LAT-1, i_dec counts down,
//                o_zero flags the last divide cycle.
//                Ports: clk, rst_n (async, active-low), i_load, i_dec, o_zero
//  Revision    : 1.0  initial release
// ============================================================================
module cov_lat_cnt
    import fastica_pkg::*;
#(
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int                CNT_W      = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [CNT_W-1:0]  C_LOAD_VAL = CNT_W'(DIV_LAT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_load) begin
            cnt_d = C_LOAD_VAL;
        end else if (i_dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_zero = (cnt_q == '0);

endmodule : cov_lat_cnt
`default_nettype wire

// File: rtl/cov_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : cov_sequencer
//  Description : Control FSM for the covariance stage. For each of N_SAMPLES
//                centred sample vectors it issues a buffer read, a multiply
//                enable and an accumulate enable, then holds the divide
//                enable for DIV_LAT cycles and pulses COV_DONE.
//                Ports: CLK, RSTn (async, active-low), bus (cov_sequencer_if
//                slave modport: GO, N_SAMPLES, [ABORT], SAMPLE_RD,
//                SAMPLE_ADDR, ACC_CLR, EN_MULTI, EN_ACC, EN_DIV, COV_BUSY,
//                COV_DONE).
//                Optional build macro: COV_SEQ_ABORT_EN adds the ABORT input,
//                which returns any active run to IDLE without COV_DONE.
//  Revision    : 1.0  initial release
// ============================================================================
module cov_sequencer
    import fastica_pkg::*;
#(
    parameter int N_W     = N_W_DEFAULT,
    parameter int DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic                CLK,
    input  logic                RSTn,
    cov_sequencer_if.slave      bus
);

    cov_state_e     state_q, state_d;
    logic [N_W-1:0] n_q,     n_d;     // latched sample count
    logic [N_W-1:0] idx_q,   idx_d;   // running sample index
    logic [N_W-1:0] addr_q,  addr_d;  // last fetched address, held between fetches

    logic div_load;
    logic div_dec;
    logic div_zero;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        div_load = 1'b0;
        div_dec  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.GO) begin
                    state_d = CLEAR;
                    n_d     = bus.N_SAMPLES;
                    idx_d   = '0;
                end
            end
            CLEAR: begin
                state_d = (n_q != '0) ? FETCH : DONE;
            end
            FETCH: begin
                addr_d  = idx_q;
                state_d = MULT;
            end
            MULT: begin
                state_d = ACC;
            end
            ACC: begin
                // Index advances on every ACC exit, including the last one;
                // SAMPLE_ADDR is taken from addr_q so it does not move with it.
                idx_d = idx_q + N_W'(1);
                if (idx_q == (n_q - N_W'(1))) begin
                    state_d  = DIV;
                    div_load = 1'b1;
                end else begin
                    state_d = FETCH;
                end
            end
            DIV: begin
                if (div_zero) begin
                    state_d = DONE;
                end else begin
                    div_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef COV_SEQ_ABORT_EN
        // Abort overrides every other transition out of a non-IDLE state.
        if (bus.ABORT && (state_q != IDLE)) begin
            state_d  = IDLE;
            div_load = 1'b0;
            div_dec  = 1'b0;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
        end
    end

    // ------------------------------------------------------------------
    // Divide-phase latency counter
    // ------------------------------------------------------------------
    cov_lat_cnt #(
        .DIV_LAT (DIV_LAT)
    ) u_lat_cnt (
        .clk    (CLK),
        .rst_n  (RSTn),
        .i_load (div_load),
        .i_dec  (div_dec),
        .o_zero (div_zero)
    );

    // ------------------------------------------------------------------
    // Moore outputs: decoded from the state register only, so an
    // asynchronous reset clears them without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign bus.SAMPLE_RD   = (state_q == FETCH);
    assign bus.SAMPLE_ADDR = (state_q == FETCH) ? idx_q : addr_q;
    assign bus.ACC_CLR     = (state_q == CLEAR);
    assign bus.EN_MULTI    = (state_q == MULT);
    assign bus.EN_ACC      = (state_q == ACC);
    assign bus.EN_DIV      = (state_q == DIV);
    assign bus.COV_DONE    = (state_q == DONE);
    assign bus.COV_BUSY    = (state_q != IDLE);

endmodule : cov_sequencer
`default_nettype wire

// File: tb/tb_cov_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cov_sequencer
//  Description : Self-checking bench for cov_sequencer. A table of per-cycle
//                {GO, N_SAMPLES, expected state letter, expected address}
//                rows covers the nominal, empty, mid-run N change and
//                back-to-back runs; hand-written sequences cover reset
//                during DIV and (with COV_SEQ_ABORT_EN) abort during MULT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cov_sequencer;

    localparam int N_W     = 10;
    localparam int DIV_LAT = 4;

    logic clk;
    logic rst_n;

    cov_sequencer_if #(.N_W(N_W)) bus ();

    cov_sequencer #(
        .N_W     (N_W),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .CLK  (clk),
        .RSTn (rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // {SAMPLE_RD, ACC_CLR, EN_MULTI, EN_ACC, EN_DIV, COV_DONE, COV_BUSY}
    logic [6:0] act;
    assign act = {bus.SAMPLE_RD, bus.ACC_CLR, bus.EN_MULTI, bus.EN_ACC,
                  bus.EN_DIV, bus.COV_DONE, bus.COV_BUSY};

    typedef struct {
        bit             go;
        logic [N_W-1:0] n;
        byte            st;
        logic [N_W-1:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [6:0] exp_of(input byte st);
        case (st)
            "C":     return 7'b0100001;
            "F":     return 7'b1000001;
            "M":     return 7'b0010001;
            "A":     return 7'b0001001;
            "D":     return 7'b0000101;
            "O":     return 7'b0000011;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic add(input bit go, input int n, input byte st, input int addr);
        vec_t v;
        v.go   = go;
        v.n    = N_W'(n);
        v.st   = st;
        v.addr = N_W'(addr);
        vecs.push_back(v);
    endtask

    task automatic add_samples(input bit go, input int n, input int first, input int last);
        for (int s = first; s <= last; s++) begin
            add(go, n, "F", s);
            add(go, n, "M", s);
            add(go, n, "A", s);
        end
    endtask

    task automatic add_div(input bit go, input int n, input int addr);
        for (int d = 0; d < DIV_LAT; d++) add(go, n, "D", addr);
    endtask

    task automatic check(input string name, input logic [6:0] exp, input logic [N_W-1:0] exp_addr);
        checks++;
        if (act !== exp || bus.SAMPLE_ADDR !== exp_addr) begin
            errors++;
            $display("FAIL %s: outs=%b addr=%0d, required outs=%b addr=%0d",
                     name, act, bus.SAMPLE_ADDR, exp, exp_addr);
        end
    endtask

    // At most one strobe high in any cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(act[6:1]) > 1) begin
                errors++;
                $display("FAIL onehot @%0t: strobes=%b, required at most one set", $time, act[6:1]);
            end
        end
    end

    initial begin
        bit found;
        int m;

        rst_n         = 1'b0;
        bus.GO        = 1'b0;
        bus.N_SAMPLES = '0;
`ifdef COV_SEQ_ABORT_EN
        bus.ABORT     = 1'b0;
`endif

        // ---------------- vector table ----------------
        // Nominal: 4 samples, DONE at k+18
        add(1, 4, "I", 0); add(0, 4, "C", 0);
        add_samples(0, 4, 0, 3); add_div(0, 4, 3);
        add(0, 4, "O", 3); add(0, 4, "I", 3);
        // Empty run: CLEAR then DONE, address held from previous run
        add(1, 0, "I", 3); add(0, 0, "C", 3); add(0, 0, "O", 3); add(0, 0, "I", 3);
        // N_SAMPLES changed to 9 during FETCH, stray GO in MULT: still 4 samples
        add(1, 4, "I", 3); add(0, 4, "C", 3);
        add(0, 9, "F", 0); add(1, 9, "M", 0); add(0, 9, "A", 0);
        add_samples(0, 9, 1, 3); add_div(0, 9, 3);
        add(0, 9, "O", 3); add(0, 9, "I", 3);
        // GO held, N=1: back-to-back runs with one IDLE cycle between
        add(1, 1, "I", 3); add(1, 1, "C", 3);
        add_samples(1, 1, 0, 0); add_div(1, 1, 0); add(1, 1, "O", 0);
        add(1, 1, "I", 0); add(0, 1, "C", 0);
        add_samples(0, 1, 0, 0); add_div(0, 1, 0); add(0, 1, "O", 0);
        add(0, 1, "I", 0); add(0, 1, "I", 0);

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", 7'b0, '0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- table loop ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            bus.GO        = vecs[i].go;
            bus.N_SAMPLES = vecs[i].n;
            @(negedge clk);
            check($sformatf("vec%0d(%c)", i, vecs[i].st), exp_of(vecs[i].st), vecs[i].addr);
            @(posedge clk); #1;
        end

        // ---------------- reset during DIV ----------------
        bus.GO = 1'b1; bus.N_SAMPLES = N_W'(2);
        @(posedge clk); #1;
        bus.GO = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.EN_DIV) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_div_wait: EN_DIV never seen, required within 60 cycles");
        end
        #2 rst_n = 1'b0;
        #1 check("rst_async_outputs", 7'b0, '0);
        @(posedge clk); #1;
        check("rst_held_outputs", 7'b0, '0);
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        bus.GO = 1'b1; bus.N_SAMPLES = N_W'(2);
        @(negedge clk);
        check("post_rst_idle", 7'b0, '0);
        @(posedge clk); #1;
        bus.GO = 1'b0;
        @(negedge clk);
        check("post_rst_clear", exp_of("C"), '0);
        @(negedge clk);
        check("post_rst_fetch0", exp_of("F"), '0);
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus.COV_DONE) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL post_rst_done: COV_DONE never seen, required within 30 cycles");
        end
        @(negedge clk);
        check("post_rst_idle_end", 7'b0, N_W'(1));

`ifdef COV_SEQ_ABORT_EN
        // ---------------- abort during MULT of sample 2 ----------------
        @(posedge clk); #1;
        bus.GO = 1'b1; bus.N_SAMPLES = N_W'(4);
        @(posedge clk); #1;
        bus.GO = 1'b0;
        found = 1'b0;
        m = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.EN_MULTI) begin
                m++;
                if (m == 3) begin found = 1'b1; bus.ABORT = 1'b1; break; end
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_wait: third EN_MULTI never seen, required within 40 cycles");
        end
        check("abort_in_mult2", exp_of("M"), N_W'(2));
        @(posedge clk); #1;
        bus.ABORT = 1'b0;
        @(negedge clk);
        check("abort_idle", 7'b0, N_W'(2));
        found = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.COV_DONE || bus.COV_BUSY) found = 1'b1;
        end
        checks++;
        if (found) begin
            errors++;
            $display("FAIL abort_quiet: COV_DONE/COV_BUSY seen after abort, required both 0");
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_cov_sequencer
`default_nettype wire

// File: doc/cov_sequencer.md
COV_SEQUENCER -- requirements
Module: cov_sequencer

Interface
REQ-001 Parameter: N_W, default 10, width of the sample count and sample address.
REQ-002 Parameter: DIV_LAT, default 4, number of cycles EN_DIV stays high (divider latency, >=1).
REQ-003 Port: CLK  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: RSTn  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: GO  in  1  start request; level sampled in IDLE.
REQ-006 Port: N_SAMPLES  in  N_W  number of centred sample vectors to process.
REQ-007 Port: SAMPLE_RD  out  1  read strobe to the centred-sample buffer.
REQ-008 Port: SAMPLE_ADDR  out  N_W  current sample index.
REQ-009 Port: ACC_CLR  out  1  clears the covariance accumulators.
REQ-010 Port: EN_MULTI  out  1  clock enable for the 10-product multiplier stage.
REQ-011 Port: EN_ACC  out  1  clock enable for the accumulate stage.
REQ-012 Port: EN_DIV  out  1  clock enable for the divide-by-N stage.
REQ-013 Port: COV_BUSY  out  1  high in every state except IDLE.
REQ-014 Port: COV_DONE  out  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, FETCH, MULT, ACC, DIV, DONE.
REQ-016 IDLE: GO=1 -> CLEAR; N_SAMPLES latched into n_reg and the sample index cleared on the same edge.
REQ-017 CLEAR: ACC_CLR=1 for exactly one cycle; goes to FETCH if n_reg!=0, else to DONE.
REQ-018 FETCH: SAMPLE_RD=1 and SAMPLE_ADDR=index for one cycle; goes to MULT.
REQ-019 MULT: EN_MULTI=1 for one cycle; goes to ACC.
REQ-020 ACC: EN_ACC=1 for one cycle; index increments on the exit edge; goes to DIV if index==n_reg-1, else to FETCH.
REQ-021 DIV: EN_DIV=1 for exactly DIV_LAT consecutive cycles, counted by an internal counter; then goes to DONE.
REQ-022 DONE: COV_DONE=1 for one cycle; unconditionally goes to IDLE.
REQ-023 Latency: with GO sampled at edge k, COV_DONE SHALL be high in cycle k+2+3*n_reg+DIV_LAT when n_reg>0, and in cycle k+2 when n_reg=0.
REQ-024 At most one of SAMPLE_RD, ACC_CLR, EN_MULTI, EN_ACC, EN_DIV, COV_DONE SHALL be high in any cycle.
REQ-025 GO and N_SAMPLES SHALL be ignored outside IDLE; changing N_SAMPLES mid-run SHALL NOT alter the run.
REQ-026 GO held high through DONE SHALL start a new run from IDLE; back-to-back runs are separated by exactly one IDLE cycle.
REQ-027 SAMPLE_ADDR SHALL hold its value outside FETCH and SHALL never exceed n_reg-1 while SAMPLE_RD=1.
REQ-028 The sequencer SHALL use clock enables only; it SHALL generate no derived or gated clocks.

Reset
REQ-029 RSTn=0 SHALL immediately force IDLE, set index and DIV counter to 0, set n_reg to 0, and drive all outputs to 0, including mid-run.
REQ-030 After RSTn deasserts, the first GO is sampled on the first rising edge with RSTn=1.

Configuration
REQ-031 With COV_SEQ_ABORT_EN defined, the block SHALL add input port ABORT (1 bit); ABORT=1 in any state other than IDLE SHALL force IDLE on the next edge without a COV_DONE pulse. ABORT takes priority over every other transition.
REQ-032 Without COV_SEQ_ABORT_EN, the ABORT port and its logic SHALL be absent; a run always ends in DONE.

Structure
REQ-033 The state enum, N_W and the DIV_LAT default SHALL reside in the shared package fastica_pkg.
REQ-034 The DIV-phase down-counter SHALL be a sub-module, cov_lat_cnt; everything else SHALL be in cov_sequencer.

Verification
REQ-035 N_SAMPLES=4, DIV_LAT=4, GO pulse -> SAMPLE_ADDR sequence 0,1,2,3; 4 EN_MULTI and 4 EN_ACC pulses; EN_DIV high for 4 cycles; COV_DONE at k+18.
REQ-036 N_SAMPLES=0, GO -> one ACC_CLR, no SAMPLE_RD/EN_*; COV_DONE at k+2.
REQ-037 GO pulsed and N_SAMPLES changed from 4 to 9 during FETCH -> run still 4 samples; COV_BUSY stays high until DONE.
REQ-038 GO held high, N_SAMPLES=1 -> COV_DONE every 2+3+DIV_LAT+1 cycles; one IDLE cycle between runs.
REQ-039 RSTn pulsed low during DIV -> outputs 0 immediately; IDLE; next GO restarts at SAMPLE_ADDR 0.
REQ-040 COV_SEQ_ABORT_EN defined, ABORT during MULT of sample 2 -> IDLE next cycle, no COV_DONE, COV_BUSY=0.
